// File: rtl/loop_replay_buffer_if.sv
// Bundle of detector/fetch-side inputs and IF/ID replay outputs for the loop replay buffer.
interface loop_replay_buffer_if #(
    parameter int unsigned XLEN = 32
);
    logic            capture_start;
    logic [XLEN-1:0] loop_start_pc;
    logic [XLEN-1:0] loop_end_pc;
    logic            fetch_valid;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_instr;
    logic            reuse_signal;
    logic            mispredict;
    logic            replay_ready;
    logic            replay_valid;
    logic [XLEN-1:0] replay_pc;
    logic [XLEN-1:0] replay_instr;
    logic            buffer_ready;
    logic            overflow;
    logic            capture_abort;

    modport master (
        output capture_start, loop_start_pc, loop_end_pc,
        output fetch_valid, fetch_pc, fetch_instr,
        output reuse_signal, mispredict, replay_ready,
        input  replay_valid, replay_pc, replay_instr,
        input  buffer_ready, overflow, capture_abort
    );

    modport slave (
        input  capture_start, loop_start_pc, loop_end_pc,
        input  fetch_valid, fetch_pc, fetch_instr,
        input  reuse_signal, mispredict, replay_ready,
        output replay_valid, replay_pc, replay_instr,
        output buffer_ready, overflow, capture_abort
    );
endinterface

// File: rtl/loop_replay_buffer.sv
// Captures a loop body during fetch and replays it to IF/ID while the loop detector
// holds reuse_signal, letting fetch and the I-cache idle.
module loop_replay_buffer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input logic                 clk,
    input logic                 reset,
    loop_replay_buffer_if.slave lrb
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READY   = 2'd2,
        REPLAY  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0] start_q, start_d;
    logic [XLEN-1:0] end_q, end_d;
    logic            overflow_q, overflow_d;
    logic            abort_q, abort_d;
    logic            wr_en;

    logic [XLEN-1:0] mem [DEPTH];

    logic [XLEN-1:0] expected_pc;
    logic            seq_ok;
    logic            last_slot;
    logic            last_entry;
    logic            handshake;

    // Sequence check: PC must follow start+4*count, be word aligned, and the loop range sane.
    assign expected_pc = start_q + (XLEN'(count_q) << 2);
    assign seq_ok      = (lrb.fetch_pc == expected_pc) && (lrb.fetch_pc[1:0] == 2'b00)
                         && (end_q >= start_q);
    assign last_slot   = (count_q == CW'(DEPTH - 1));
    assign last_entry  = (CW'(rd_ptr_q) == (count_q - CW'(1)));
    assign handshake   = (state_q == REPLAY) && lrb.replay_ready;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        start_d    = start_q;
        end_d      = end_q;
        overflow_d = 1'b0;
        abort_d    = 1'b0;
        wr_en      = 1'b0;

        if (lrb.mispredict) begin
            state_d  = IDLE;
            count_d  = '0;
            rd_ptr_d = '0;
        end else if (lrb.capture_start) begin
            state_d  = CAPTURE;
            count_d  = '0;
            rd_ptr_d = '0;
            start_d  = lrb.loop_start_pc;
            end_d    = lrb.loop_end_pc;
        end else begin
            case (state_q)
                IDLE: ;
                CAPTURE: begin
                    if (lrb.fetch_valid) begin
                        if (!seq_ok) begin
                            abort_d = 1'b1;
                            state_d = IDLE;
                            count_d = '0;
                        end else begin
                            wr_en   = 1'b1;
                            count_d = count_q + CW'(1);
                            if (lrb.fetch_pc == end_q) begin
                                state_d = READY;
                            end else if (last_slot) begin
                                overflow_d = 1'b1;
                                state_d    = IDLE;
                                count_d    = '0;
                            end
                        end
                    end
                end
                READY: begin
                    if (lrb.reuse_signal) begin
                        state_d  = REPLAY;
                        rd_ptr_d = '0;
                    end
                end
                REPLAY: begin
                    if (handshake) begin
                        rd_ptr_d = last_entry ? '0 : rd_ptr_q + AW'(1);
                    end
                    // Detector dropped reuse: finish this cycle's handshake, then rewind.
                    if (!lrb.reuse_signal) begin
                        state_d  = READY;
                        rd_ptr_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            start_q    <= '0;
            end_q      <= '0;
            overflow_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            start_q    <= start_d;
            end_q      <= end_d;
            overflow_q <= overflow_d;
            abort_q    <= abort_d;
        end
    end

    // Body storage; contents are meaningless outside READY/REPLAY so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[AW'(count_q)] <= lrb.fetch_instr;
        end
    end

    assign lrb.replay_valid  = (state_q == REPLAY);
    assign lrb.replay_pc     = (state_q == REPLAY) ? start_q + (XLEN'(rd_ptr_q) << 2) : '0;
    assign lrb.replay_instr  = (state_q == REPLAY) ? mem[rd_ptr_q] : '0;
    assign lrb.buffer_ready  = (state_q == READY) || (state_q == REPLAY);
    assign lrb.overflow      = overflow_q;
    assign lrb.capture_abort = abort_q;

endmodule

// File: doc/loop_replay_buffer.md
Name: loop_replay_buffer

Overview:
Instruction-side partner of stream_loop_detector. While the detector is tracking a loop, this block captures the loop body as it is fetched. When the detector asserts reuse_signal, it replays the captured instructions to IF/ID with PCs, so fetch and I-cache stay idle for the loop. It sits between IF and the IF/ID register, alongside the detector. A mispredict aborts replay and drops the contents.

Parameters:
XLEN, 32, instruction and PC width
DEPTH, 16, maximum loop body length in instructions (power of 2)
AW, 4, index width, log2(DEPTH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
capture_start  input  1  one-cycle pulse from detector: backward branch seen, start capturing
loop_start_pc  input  XLEN  branch target (first loop PC), sampled on capture_start
loop_end_pc  input  XLEN  PC of the backward branch, sampled on capture_start
fetch_valid  input  1  IF stage presents a valid instruction
fetch_pc  input  XLEN  PC of the fetched instruction
fetch_instr  input  XLEN  fetched instruction word
reuse_signal  input  1  level from detector: serve instructions from the buffer
mispredict  input  1  branch mispredict / loop exit: abort
replay_ready  input  1  IF/ID can accept (not stalled)
replay_valid  output  1  replay_pc/replay_instr valid
replay_pc  output  XLEN  PC of the replayed instruction
replay_instr  output  XLEN  replayed instruction
buffer_ready  output  1  a complete loop body is held
overflow  output  1  one-cycle pulse: loop longer than DEPTH, capture abandoned
capture_abort  output  1  one-cycle pulse: non-sequential fetch during capture

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; count=0, rd_ptr=0, start/end registers=0. All outputs are 0. Memory contents are don't-care.
- States: IDLE, CAPTURE, READY, REPLAY. All transitions happen on the rising clk edge.
- Priority each cycle: mispredict > capture_start > the state-specific rule.
- mispredict=1 in any state: go to IDLE, count=0, rd_ptr=0, replay_valid=0 from the next cycle.
- capture_start=1, any state except the mispredict case:
  - latch loop_start_pc and loop_end_pc, set count=0, go to CAPTURE.
  - This also restarts from READY or REPLAY; the old contents are discarded.
- IDLE: outputs are idle; fetch traffic is ignored.
- CAPTURE, on fetch_valid=1:
  - expected PC = start + 4*count, computed mod 2^XLEN.
  - fetch_pc != expected: pulse capture_abort and go to IDLE.
  - Otherwise write fetch_instr to mem[count] and increment count.
  - If fetch_pc == loop_end_pc (this entry is the branch): go to READY with count = body length.
  - Else if count was DEPTH-1 before the write: pulse overflow and go to IDLE.
  - loop_end_pc < loop_start_pc, or a misaligned PC, fails the sequence check and aborts.
- READY: buffer_ready=1.
  - reuse_signal=1: go to REPLAY with rd_ptr=0.
  - Contents are held indefinitely otherwise.
- REPLAY: buffer_ready=1, replay_valid=1, replay_instr=mem[rd_ptr], replay_pc=start + 4*rd_ptr.
  - Outputs are combinational from registered rd_ptr.
  - First valid appears the cycle after reuse_signal is sampled high in READY (1-cycle latency).
  - Handshake: rd_ptr advances only when replay_valid and replay_ready are both 1. Outputs stay stable while replay_ready=0.
  - Wrap: on a handshake with rd_ptr == count-1 (the backward branch), rd_ptr becomes 0.
  - reuse_signal=0: return to READY after finishing any handshake that cycle, and set rd_ptr=0.
- A single-instruction loop (count=1) replays entry 0 every cycle.
- fetch inputs are ignored in READY and REPLAY.

Test Plan:
- Capture and replay: capture_start with start=0x00, end=0x08; fetch 0x00/0x04/0x08 with words A/B/C; then reuse_signal=1 and replay_ready=1. Required: buffer_ready after 3 fetches; replay stream (0x00,A),(0x04,B),(0x08,C),(0x00,A)...
- Stall: during replay, hold replay_ready=0 for 3 cycles at 0x04. Required: replay_pc=0x04 and replay_instr=B held stable; resumes at 0x08.
- Mispredict during replay: assert at rd_ptr=2. Required: next cycle replay_valid=0, buffer_ready=0, state IDLE; reuse_signal alone does not restart replay.
- Overflow: start=0x00, end=0x100, DEPTH=16, sequential fetches. Required: overflow pulse on the 16th fetch (pc 0x3C), then IDLE.
- Non-sequential capture: start=0x00, end=0x20, fetches 0x00 then 0x10. Required: capture_abort pulse and IDLE.
- Async reset mid-REPLAY: drive reset=0 between clock edges. Required: all outputs 0 immediately; after release, state IDLE.
